// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: sequencer state encoding, reset-cause codes and the shared counter width.
package reset_seq_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      BUS_UP    = 2'd1,
      PERIPH_UP = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_BTN  = 2'b10;
   localparam logic [1:0] CAUSE_SOFT = 2'b11;

   // Lock loss outranks the button, which outranks a software request.
   function automatic logic [1:0] pickCause(input logic lockLost, input logic btnPressed);
      if (lockLost)
         return CAUSE_LOCK;
      else if (btnPressed)
         return CAUSE_BTN;
      else
         return CAUSE_SOFT;
   endfunction

endpackage

// File: rtl/reset_seq_sync_filter.sv
// sync_filter: 2-FF synchroniser followed by a consecutive-sample filter on the synchronised level.
module sync_filter #(
   parameter int CYCLES    = 64,
   parameter bit ASYM_FALL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic filt_o
);

   localparam int            CW      = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

   logic          meta_q;
   logic          sync_q;
   logic          filt_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   // The output follows only after CYCLES disagreeing samples plus one more that still
   // disagrees; with ASYM_FALL a single low sample drops it straight away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (sync_q == filt_q) begin
         cnt_q <= '0;
      end else if (ASYM_FALL && !sync_q) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_q  <= '0;
         filt_q <= sync_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/reset_seq.sv
// reset_seq: releases bus, peripheral and CPU resets in order once lock is stable and the button idle.
// Define RESET_SEQ_SOFT_RST_EN to add the soft_rst_req input and its minimum HOLD time.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int STAGE_DELAY     = 16,
   parameter int LOCK_FILTER     = 64,
   parameter int DEBOUNCE_CYCLES = 50000
`ifdef RESET_SEQ_SOFT_RST_EN
   ,
   parameter int SOFT_HOLD       = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       locked,
   input  logic       reset_sw,
`ifdef RESET_SEQ_SOFT_RST_EN
   input  logic       soft_rst_req,
`endif
   output logic       rst_bus,
   output logic       rst_periph,
   output logic       rst_core,
   output logic       ready,
   output logic [1:0] rst_cause
);

   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);

   logic             lockOk;
   logic             btn;
   logic             softReq;
   logic             softIdle;
   logic             fault;
   state_e           state_q;
   logic [CNT_W-1:0] stageCnt_q;
   logic             rstBus_q;
   logic             rstPeriph_q;
   logic             rstCore_q;
   logic             ready_q;
   logic [1:0]       cause_q;

   sync_filter #(
      .CYCLES    (LOCK_FILTER),
      .ASYM_FALL (1'b1)
   ) u_lock_filter (
      .clk     (clk),
      .rst     (reset),
      .async_i (locked),
      .filt_o  (lockOk)
   );

   sync_filter #(
      .CYCLES    (DEBOUNCE_CYCLES),
      .ASYM_FALL (1'b0)
   ) u_btn_debounce (
      .clk     (clk),
      .rst     (reset),
      .async_i (reset_sw),
      .filt_o  (btn)
   );

`ifdef RESET_SEQ_SOFT_RST_EN
   logic [CNT_W-1:0] softCnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         softCnt_q <= '0;
      else if (soft_rst_req)
         softCnt_q <= CNT_W'(SOFT_HOLD);
      else if (softCnt_q != '0)
         softCnt_q <= softCnt_q - 1'b1;
   end

   assign softReq  = soft_rst_req;
   assign softIdle = (softCnt_q == '0);
`else
   assign softReq  = 1'b0;
   assign softIdle = 1'b1;
`endif

   assign fault = !lockOk | btn | softReq;

   // Cause is only captured when leaving a non-HOLD state, so a fault arriving during HOLD
   // leaves the original cause visible to software.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= HOLD;
         stageCnt_q  <= '0;
         rstBus_q    <= 1'b1;
         rstPeriph_q <= 1'b1;
         rstCore_q   <= 1'b1;
         ready_q     <= 1'b0;
         cause_q     <= CAUSE_POR;
      end else if (fault) begin
         state_q     <= HOLD;
         stageCnt_q  <= '0;
         rstBus_q    <= 1'b1;
         rstPeriph_q <= 1'b1;
         rstCore_q   <= 1'b1;
         ready_q     <= 1'b0;
         if (state_q != HOLD)
            cause_q <= pickCause(!lockOk, btn);
      end else begin
         case (state_q)
            HOLD: begin
               if (!softIdle) begin
                  stageCnt_q <= '0;
               end else if (stageCnt_q == STAGE_LAST) begin
                  state_q    <= BUS_UP;
                  stageCnt_q <= '0;
                  rstBus_q   <= 1'b0;
               end else begin
                  stageCnt_q <= stageCnt_q + 1'b1;
               end
            end
            BUS_UP: begin
               if (stageCnt_q == STAGE_LAST) begin
                  state_q     <= PERIPH_UP;
                  stageCnt_q  <= '0;
                  rstPeriph_q <= 1'b0;
               end else begin
                  stageCnt_q <= stageCnt_q + 1'b1;
               end
            end
            PERIPH_UP: begin
               if (stageCnt_q == STAGE_LAST) begin
                  state_q    <= RUN;
                  stageCnt_q <= '0;
                  rstCore_q  <= 1'b0;
                  ready_q    <= 1'b1;
               end else begin
                  stageCnt_q <= stageCnt_q + 1'b1;
               end
            end
            RUN: begin
               stageCnt_q <= '0;
            end
            default: begin
               state_q <= HOLD;
            end
         endcase
      end
   end

   assign rst_bus    = rstBus_q;
   assign rst_periph = rstPeriph_q;
   assign rst_core   = rstCore_q;
   assign ready      = ready_q;
   assign rst_cause  = cause_q;

endmodule
